gb_cpu_regfile: RTL
===================

Name: gb_cpu_regfile

Overview:
- Architectural register file of the Game Boy CPU.
- Holds A, F, B, C, D, E, H, L, SP and PC.
- Supplies the 16-bit operand that feeds the IDU (inc/dec unit) and the address bus.
- Accepts IDU results, ALU/load byte results and ALU flag updates as writeback.
- Sits between the control unit (selects, enables) and the IDU/ALU datapath.

Parameters:
- PC_RESET, 16'h0000, PC value after reset.
- SP_RESET, 16'h0000, SP value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- rd8_sel_a  input  4  reg8_sel_t, byte read port A select
- rd8_a  output  8  byte read port A data
- rd8_sel_b  input  4  reg8_sel_t, byte read port B select
- rd8_b  output  8  byte read port B data
- rd16_sel  input  3  reg16_sel_t, pair read select (drives IDU input / address bus)
- rd16  output  16  pair read data
- wr8_en  input  1  byte write enable
- wr8_sel  input  4  reg8_sel_t, byte write target
- wr8_data  input  8  byte write data
- wr16_en  input  1  pair write enable (IDU writeback)
- wr16_sel  input  3  reg16_sel_t, pair write target
- wr16_data  input  16  pair write data
- flags_en  input  4  per-flag update enables {Z,N,H,C}
- flags_in  input  4  new flag values {Z,N,H,C}
- flags  output  4  current {Z,N,H,C} = F[7:4]
- pc  output  16  current PC
- sp  output  16  current SP

Behaviour:
- Reset: every byte register = 8'h00; PC = PC_RESET; SP = SP_RESET.
  - Reset is synchronous and takes priority over all writes in the same cycle.
  - Reset mid-sequence discards any pending writes.
- Reads are combinational from current state. There is no write-to-read bypass: a write lands at the clock edge and is visible in the following cycle.
- reg8_sel_t encodings: B=0, C=1, D=2, E=3, H=4, L=5, F=6, A=7, SPH=8, SPL=9, PCH=10, PCL=11.
  - Codes 12-15 read 8'h00 and are ignored on write.
- reg16_sel_t encodings: BC=0, DE=1, HL=2, SP=3, AF=4, PC=5.
  - Codes 6-7 read 16'h0000 and are ignored on write.
  - Pair byte order is {high, low}: BC = {B, C}, AF = {A, F}.
- F[3:0] is hardwired 0 on read and on every write path, including wr16 to AF and wr8 to F.
- Write merge applies per byte, and per bit for F. Precedence, lowest to highest: wr16, flags_en, wr8.
  - If wr16 and wr8 hit the same byte, the wr8 byte wins; the other byte of the pair still takes wr16_data.
  - flags_en[i] overrides the wr16 bit for F; a wr8 to F overrides flags_en entirely.
- wr16_data is used as-is. Arithmetic (inc/dec wrap FFFF<->0000) is done upstream; no carry or flag side effects.
- The regfile has no implicit PC increment. All PC changes arrive through wr16 (PC) or wr8 (PCH/PCL).
- Simultaneous writes to different registers all take effect in the same cycle.
- Outputs pc, sp and flags reflect registered state only.

Decomposition:
- Add reg8_sel_t and reg16_sel_t (enums with the encodings above) to gb_cpu_common_pkg, next to idu_opcode_t.
- Add constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0 to the same package.
- No sub-module: a flat always_ff with combinational read muxes.

Test Plan:
- Reset check: assert reset, including alongside wr16_en=1 to PC with 16'h1234.
  -> Next cycle pc=16'h0000, sp=16'h0000, rd16(HL)=0, flags=0.
- Pair write/read: wr16 BC=16'hBEEF.
  -> Next cycle rd8 B=8'hBE, rd8 C=8'hEF, rd16(BC)=16'hBEEF.
  -> Same-cycle read still returns the old value 16'h0000.
- F hardwired nibble: wr16 AF=16'h12FF.
  -> rd16(AF)=16'h12F0, flags=4'hF.
  -> Then flags_en=4'b0101, flags_in=4'b0000 gives flags=4'b1010 and F=8'hA0.
- Collision: same cycle wr16 HL=16'h1111 and wr8 L=8'h22.
  -> HL=16'h1122.
  -> Same cycle wr16 AF=16'h00F0, flags_en=4'b1000, flags_in=0, wr8 disabled gives F=8'h70.
- PC wrap via IDU loop: PC=16'hFFFF; feed rd16(PC) through an IDU model with IDU_INC into wr16 PC.
  -> pc=16'h0000 next cycle.
  -> wr8 PCH=8'hC0 then PCL=8'h50 gives pc=16'hC050.
- Invalid selects: wr8_sel=4'd13 with data 8'hAA, and wr16_sel=3'd7.
  -> No register changes.
  -> rd8 sel 13 returns 8'h00; rd16 sel 7 returns 16'h0000.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the Game Boy CPU datapath blocks.
package gb_cpu_common_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned REG8_SEL_W  = 4;
  localparam int unsigned REG16_SEL_W = 3;
  localparam int unsigned FLAG_W      = 4;
  localparam int unsigned NUM_BYTE_VIEW = 16;

  // IDU operation applied to the 16-bit operand on its way back to a pair
  typedef enum logic [1:0] {
    IDU_PASS = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2
  } idu_opcode_t;

  // Byte register selects; codes 12-15 are unmapped
  typedef enum logic [3:0] {
    R8_B   = 4'd0,
    R8_C   = 4'd1,
    R8_D   = 4'd2,
    R8_E   = 4'd3,
    R8_H   = 4'd4,
    R8_L   = 4'd5,
    R8_F   = 4'd6,
    R8_A   = 4'd7,
    R8_SPH = 4'd8,
    R8_SPL = 4'd9,
    R8_PCH = 4'd10,
    R8_PCL = 4'd11
  } reg8_sel_t;

  // Register pair selects; codes 6-7 are unmapped
  typedef enum logic [2:0] {
    R16_BC = 3'd0,
    R16_DE = 3'd1,
    R16_HL = 3'd2,
    R16_SP = 3'd3,
    R16_AF = 3'd4,
    R16_PC = 3'd5
  } reg16_sel_t;

  // Bit positions within the {Z,N,H,C} flag nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/gb_cpu_regfile.sv
// Architectural register file: A,F,B,C,D,E,H,L,SP,PC with byte/pair/flag writeback.
module gb_cpu_regfile
  import gb_cpu_common_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rd8_sel_a,
  output logic [7:0]  rd8_a,
  input  logic [3:0]  rd8_sel_b,
  output logic [7:0]  rd8_b,
  input  logic [2:0]  rd16_sel,
  output logic [15:0] rd16,
  input  logic        wr8_en,
  input  logic [3:0]  wr8_sel,
  input  logic [7:0]  wr8_data,
  input  logic        wr16_en,
  input  logic [2:0]  wr16_sel,
  input  logic [15:0] wr16_data,
  input  logic [3:0]  flags_en,
  input  logic [3:0]  flags_in,
  output logic [3:0]  flags,
  output logic [15:0] pc,
  output logic [15:0] sp
);

  // F keeps only its upper nibble; the lower nibble does not exist as state
  logic [DATA_W-1:0] a_q, b_q, c_q, d_q, e_q, h_q, l_q;
  logic [DATA_W-1:0] a_d, b_d, c_d, d_d, e_d, h_d, l_d;
  logic [FLAG_W-1:0] f_q, f_d;
  logic [WORD_W-1:0] sp_q, sp_d, pc_q, pc_d;

  logic [DATA_W-1:0] byte_view [NUM_BYTE_VIEW];

  // Write merge: wr16 first, then per-bit flag updates, then wr8 on top
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    d_d  = d_q;
    e_d  = e_q;
    h_d  = h_q;
    l_d  = l_q;
    f_d  = f_q;
    sp_d = sp_q;
    pc_d = pc_q;

    if (wr16_en) begin
      case (reg16_sel_t'(wr16_sel))
        R16_BC: begin
          b_d = wr16_data[15:8];
          c_d = wr16_data[7:0];
        end
        R16_DE: begin
          d_d = wr16_data[15:8];
          e_d = wr16_data[7:0];
        end
        R16_HL: begin
          h_d = wr16_data[15:8];
          l_d = wr16_data[7:0];
        end
        R16_SP: sp_d = wr16_data;
        R16_AF: begin
          a_d = wr16_data[15:8];
          f_d = wr16_data[7:4];
        end
        R16_PC: pc_d = wr16_data;
        default: ;
      endcase
    end

    for (int i = 0; i < int'(FLAG_W); i++) begin
      if (flags_en[i]) f_d[i] = flags_in[i];
    end

    if (wr8_en) begin
      case (reg8_sel_t'(wr8_sel))
        R8_B:   b_d = wr8_data;
        R8_C:   c_d = wr8_data;
        R8_D:   d_d = wr8_data;
        R8_E:   e_d = wr8_data;
        R8_H:   h_d = wr8_data;
        R8_L:   l_d = wr8_data;
        R8_F:   f_d = wr8_data[7:4];
        R8_A:   a_d = wr8_data;
        R8_SPH: sp_d[15:8] = wr8_data;
        R8_SPL: sp_d[7:0]  = wr8_data;
        R8_PCH: pc_d[15:8] = wr8_data;
        R8_PCL: pc_d[7:0]  = wr8_data;
        default: ;
      endcase
    end
  end

  // State register; synchronous reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      e_q  <= '0;
      h_q  <= '0;
      l_q  <= '0;
      f_q  <= '0;
      sp_q <= SP_RESET;
      pc_q <= PC_RESET;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      d_q  <= d_d;
      e_q  <= e_d;
      h_q  <= h_d;
      l_q  <= l_d;
      f_q  <= f_d;
      sp_q <= sp_d;
      pc_q <= pc_d;
    end
  end

  // Byte-addressable view of current state, indexed by reg8 select code
  always_comb begin
    for (int i = 0; i < int'(NUM_BYTE_VIEW); i++) byte_view[i] = '0;
    byte_view[R8_B]   = b_q;
    byte_view[R8_C]   = c_q;
    byte_view[R8_D]   = d_q;
    byte_view[R8_E]   = e_q;
    byte_view[R8_H]   = h_q;
    byte_view[R8_L]   = l_q;
    byte_view[R8_F]   = {f_q, 4'h0};
    byte_view[R8_A]   = a_q;
    byte_view[R8_SPH] = sp_q[15:8];
    byte_view[R8_SPL] = sp_q[7:0];
    byte_view[R8_PCH] = pc_q[15:8];
    byte_view[R8_PCL] = pc_q[7:0];
  end

  // Byte read ports
  always_comb begin
    rd8_a = byte_view[rd8_sel_a];
    rd8_b = byte_view[rd8_sel_b];
  end

  // Pair read port feeding the IDU and address bus
  always_comb begin
    rd16 = '0;
    case (reg16_sel_t'(rd16_sel))
      R16_BC: rd16 = {b_q, c_q};
      R16_DE: rd16 = {d_q, e_q};
      R16_HL: rd16 = {h_q, l_q};
      R16_SP: rd16 = sp_q;
      R16_AF: rd16 = {a_q, f_q, 4'h0};
      R16_PC: rd16 = pc_q;
      default: rd16 = '0;
    endcase
  end

  // Direct state taps
  always_comb begin
    flags = f_q;
    pc    = pc_q;
    sp    = sp_q;
  end

endmodule
